serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 22 ++
 rtl/serial_subtractor_sub_digit.sv | 27 ++
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM states, default
// geometry and the digit-counter sizing helper.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DIGIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Width of a counter that indexes width/digit digits; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned width,
                                            input int unsigned digit);
    int unsigned n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit subtract cell: d = x - y - bin, built as a ripple
// of full-subtractor bits with the borrow propagating upward.
module sub_digit
  import serial_sub_pkg::*;
#(
  parameter int unsigned DIGIT = DEFAULT_DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] br;

  assign br[0] = bin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign d[i]    = x[i] ^ y[i] ^ br[i];
    // Borrow out when y exceeds x, or when they match and a borrow arrives.
    assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
  end

  assign bout = br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b, processed LSB digit first with the
// borrow held in a flop between cycles; start/busy/done handshake.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

  if ((DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_geometry_check
    $error("serial_subtractor: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             bint;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             a_msb;
  logic             b_msb;
  logic [DIGIT-1:0] cell_d;
  logic             cell_bout;

  sub_digit #(
    .DIGIT (DIGIT)
  ) u_cell (
    .x    (a_sr[DIGIT-1:0]),
    .y    (b_sr[DIGIT-1:0]),
    .bin  (bint),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values; the shift registers are small flops, so
  // they are reset along with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bint     <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with done is refused, forcing an idle gap.
          if (start && !done) begin
            a_sr  <= a;
            b_sr  <= b;
            r_sr  <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            bint  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          a_sr <= a_sr >> DIGIT;
          b_sr <= b_sr >> DIGIT;
          r_sr <= (r_sr >> DIGIT) | (WIDTH'(cell_d) << (WIDTH - DIGIT));
          bint <= cell_bout;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_DIGIT) begin
            state <= FIN;
          end
        end

        FIN: begin
          diff     <= r_sr;
          borrow   <= bint;
          overflow <= (a_msb != b_msb) && (r_sr[WIDTH-1] != a_msb);
          zero     <= (r_sr == '0);
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8, DIGIT=1): latency, busy
// window, result flags, start-while-busy rejection and mid-job reset.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
  logic       overflow;
  logic       zero;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(
    .WIDTH (8),
    .DIGIT (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one job, optionally poking start during RUN cycle inject_at and on
  // the done cycle, then check latency, busy window and the published flags.
  task automatic run_job(input string name, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input logic ez, input int inject_at, input bit inject_done);
    int         lat;
    int         busy_cnt;
    bit         held;
    logic [7:0] prev;
    prev     = diff;
    held     = 1'b1;
    busy_cnt = 0;
    lat      = -1;
    a        = av;
    b        = bv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    for (int k = 0; k < 30; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
      if (diff !== prev) held = 1'b0;
      if (k == inject_at) begin
        start = 1'b1;
        a     = 8'd1;
        b     = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({name, "_latency"},   lat,      32'd9);
    check({name, "_busy_cnt"},  busy_cnt, 32'd9);
    check({name, "_busy_done"}, busy,     1'b0);
    check({name, "_diff_hold"}, held,     1'b1);
    check({name, "_diff"},      diff,     ed);
    check({name, "_borrow"},    borrow,   eb);
    check({name, "_overflow"},  overflow, eo);
    check({name, "_zero"},      zero,     ez);
    if (inject_done) begin
      start = 1'b1;
      a     = 8'd1;
      b     = 8'd1;
    end
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_pulse"}, done, 1'b0);
    if (inject_done) check({name, "_start_on_done_busy"}, busy, 1'b0);
  endtask

  initial begin
    int extra_done;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_diff",     diff,     8'd0);
    check("rst_borrow",   borrow,   1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_zero",     zero,     1'b1);
    rst = 1'b0;
    @(negedge clk);

    run_job("j200_55", 8'd200, 8'd55,  8'd145, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    run_job("j5_10",   8'd5,   8'd10,  8'hFB,  1'b1, 1'b0, 1'b0, -1, 1'b0);
    run_job("j7f_ff",  8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1, 1'b0, -1, 1'b0);
    run_job("j80_01",  8'h80,  8'h01,  8'h7F,  1'b0, 1'b1, 1'b0, -1, 1'b0);

    // Reset in the middle of a job: everything returns to reset values.
    a     = 8'd100;
    b     = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy",     busy,     1'b0);
    check("midrst_done",     done,     1'b0);
    check("midrst_diff",     diff,     8'd0);
    check("midrst_zero",     zero,     1'b1);
    check("midrst_overflow", overflow, 1'b0);
    @(negedge clk);
    rst        = 1'b0;
    extra_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    check("midrst_no_done", extra_done, 32'd0);
    run_job("after_rst", 8'd100, 8'd1, 8'd99, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    run_job("j3c_3c", 8'h3C, 8'h3C, 8'd0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    run_job("j0_0",   8'd0,  8'd0,  8'd0, 1'b0, 1'b0, 1'b1, -1, 1'b0);

    // Starts during RUN and on the done cycle must both be ignored.
    run_job("j9_4_busy", 8'd9, 8'd4, 8'd5, 1'b0, 1'b0, 1'b0, 3, 1'b1);
    extra_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    check("busy_single_done", extra_done, 32'd0);
    check("busy_diff_kept",   diff,       8'd5);
    run_job("idle_start", 8'd1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
